// File: rtl/lsu_mem_stage.sv
// Memory stage: address/strobe generation, data-memory handshake,
// load alignment and extension, one writeback beat per accepted op.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_e;

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic        ld_q, ld_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdat_q, wdat_d;
  logic        wbv_q, wbv_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic [31:0] wbd_q, wbd_d;
  logic        wbe_q, wbe_d;

  logic        bad;
  logic        to;
  logic [31:0] sh;
  logic [31:0] ldat;
  logic [3:0]  strb;
  logic [31:0] sdat;

  assign ex_ready  = (state_q == IDLE);
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdat_q;
  assign wb_valid  = wbv_q;
  assign wb_rd     = wbrd_q;
  assign wb_data   = wbd_q;
  assign wb_err    = wbe_q;

  // Decode accept-time error, strobes, store data and aligned load data
  always_comb begin
    bad  = 1'b0;
    strb = 4'b1111;
    sdat = ex_store_data;
    ldat = 32'h0;
    sh   = 32'h0;
    if (ex_is_load && ex_is_store) bad = 1'b1;
    if (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11)
      bad = 1'b1;
    if (ex_funct3[1:0] == 2'b01 && ex_result[0])
      bad = 1'b1;
    if (ex_funct3[1:0] == 2'b10 && ex_result[1:0] != 2'b00)
      bad = 1'b1;
    unique case (ex_funct3[1:0])
      2'b00: begin
        strb = 4'b0001 << ex_result[1:0];
        sdat = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        strb = 4'b0011 << ex_result[1:0];
        sdat = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
    sh = mem_rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ldat = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ldat = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ldat = {24'h0, sh[7:0]};
      3'b101:  ldat = {16'h0, sh[15:0]};
      default: ldat = mem_rdata;
    endcase
  end

  assign to = (cnt_q >= TO_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    off_d   = off_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    wbv_d   = 1'b0;
    wbrd_d  = wbrd_q;
    wbd_d   = wbd_q;
    wbe_d   = wbe_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          f3_d  = ex_funct3;
          ld_d  = ex_is_load;
          off_d = ex_result[1:0];
          rd_d  = ex_rd;
          res_d = ex_result;
          err_d = 1'b0;
          if (!ex_is_load && !ex_is_store) begin
            state_d = RESP;
          end else if (bad) begin
            err_d   = 1'b1;
            rd_d    = 5'd0;
            state_d = RESP;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            cnt_d   = 16'd0;
            addr_d  = {ex_result[31:2], 2'b00};
            we_d    = ex_is_store ? strb : 4'b0000;
            wdat_d  = ex_is_store ? sdat : 32'h0;
            if (ex_is_store) rd_d = 5'd0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = ld_q ? WAIT : RESP;
        end else if (to) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rd_d    = 5'd0;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          res_d   = ldat;
          state_d = RESP;
        end else if (to) begin
          err_d   = 1'b1;
          rd_d    = 5'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        wbv_d   = 1'b1;
        wbrd_d  = rd_q;
        wbd_d   = res_q;
        wbe_d   = err_q;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      ld_q    <= 1'b0;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      we_q    <= 4'h0;
      wdat_q  <= 32'h0;
      wbv_q   <= 1'b0;
      wbrd_q  <= 5'd0;
      wbd_q   <= 32'h0;
      wbe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      wbv_q   <= wbv_d;
      wbrd_q  <= wbrd_d;
      wbd_q   <= wbd_d;
      wbe_q   <= wbe_d;
    end
  end

endmodule
